dm_uncache_ctrl: RTL and testbench

DM_UNCACHE_CTRL -- requirements
Module: dm_uncache_ctrl

---
 rtl/dm_uncache_ctrl_pkg.sv | 44 ++++
 rtl/dm_uncache_ctrl_if.sv | 35 +++
 rtl/dm_uncache_ctrl.sv | 139 +++++++++++++
 tb/tb_dm_uncache_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_uncache_ctrl_pkg.sv
// Shared definitions for the data-side uncached access controller.
// Holds the controller state encoding, access size codes, exception codes
// and the latched request payload.
package dm_uncache_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned EXC_W  = 5;

    // Access size codes carried on rd_type / wr_type
    localparam logic [TYPE_W-1:0] TYPE_BYTE = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_HALF = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_WORD = 3'b010;

    // Exception codes shared with the rest of the pipeline
    localparam logic [EXC_W-1:0] EXC_INT  = 5'h00;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;
    localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
    localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'h0a;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'h0c;

    // Uncached controller states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } uc_state_e;

    // Request captured from MEM2 when the controller accepts it
    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [TYPE_W-1:0] acc_type;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } uc_req_t;

endpackage

// File: rtl/dm_uncache_ctrl_if.sv
// Bus-side interface of the uncached controller.
// master: controller (drives rd/wr requests, receives rdy and read returns)
// slave : bus / cache selector side.
interface dm_uncache_ctrl_if;
    import dm_uncache_ctrl_pkg::*;

    logic              rd_req;
    logic [TYPE_W-1:0] rd_type;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [DATA_W-1:0] ret_data;
    logic              wr_req;
    logic [TYPE_W-1:0] wr_type;
    logic [ADDR_W-1:0] wr_addr;
    logic [STRB_W-1:0] wr_wstrb;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rdy;

    modport master (
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  wr_rdy
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output wr_rdy
    );

endinterface

// File: rtl/dm_uncache_ctrl.sv
// Data-side uncached access controller.
// Accepts one load/store from MEM2 in IDLE, issues a single read or posted
// write on the bus, and signals completion with data_ok for one cycle.
// Ports:
//   clk, resetn            clock, async active-low reset
//   valid, op, addr,       request from MEM2 (op: 1 store, 0 load)
//   acc_type, wstrb, wdata access size, byte enables, store data
//   data_ok                free or access complete (combinational)
//   rdata                  last completed load word
//   bus                    read/write request and read return channel
module dm_uncache_ctrl
    import dm_uncache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [TYPE_W-1:0] acc_type,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata,
    dm_uncache_ctrl_if.master bus
);

    uc_state_e state;
    uc_state_e state_nxt;
    uc_req_t   req_q;
    logic      rd_req_q;
    logic      wr_req_q;
    logic      accept;
    logic      rd_hs;
    logic      wr_hs;
    logic      ret_hit;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, accept strobe and data_ok
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rd_hs     = 1'b0;
        wr_hs     = 1'b0;
        ret_hit   = 1'b0;
        data_ok   = 1'b0;
        case (state)
            IDLE: begin
                // Stall MEM2 in the very cycle it presents a request
                data_ok = ~valid;
                if (valid) begin
                    accept    = 1'b1;
                    state_nxt = op ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                // Latched op also qualifies the handshake so a stray rdy
                // on the other channel can never advance the access
                rd_hs = rd_req_q & bus.rd_rdy & ~req_q.op;
                if (rd_hs) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Only the last beat carries the word; earlier beats dropped
                ret_hit = bus.ret_valid & bus.ret_last;
                if (ret_hit) begin
                    state_nxt = DONE;
                end
            end
            WR_REQ: begin
                wr_hs = wr_req_q & bus.wr_rdy & req_q.op;
                if (wr_hs) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                data_ok   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture; only written on acceptance so later valids are ignored
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= uc_req_t'{
                op:       op,
                addr:     addr,
                acc_type: acc_type,
                wstrb:    wstrb,
                wdata:    wdata
            };
        end
    end

    // Bus request strobes registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
        end else begin
            rd_req_q <= (state_nxt == RD_REQ);
            wr_req_q <= (state_nxt == WR_REQ);
        end
    end

    // Load result, held until the next load completes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (ret_hit) begin
            rdata <= bus.ret_data;
        end
    end

    // Bus fields come straight from the latched request, address unaligned
    assign bus.rd_req   = rd_req_q;
    assign bus.rd_type  = req_q.acc_type;
    assign bus.rd_addr  = req_q.addr;
    assign bus.wr_req   = wr_req_q;
    assign bus.wr_type  = req_q.acc_type;
    assign bus.wr_addr  = req_q.addr;
    assign bus.wr_wstrb = req_q.wstrb;
    assign bus.wr_data  = req_q.wdata;

endmodule

// File: tb/tb_dm_uncache_ctrl.sv
// Testbench for dm_uncache_ctrl: directed scenarios followed by a randomized
// stream of loads/stores against a transaction-level model with a scoreboard.
module tb_dm_uncache_ctrl;
    import dm_uncache_ctrl_pkg::*;

    localparam int unsigned N_RAND = 300;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        op = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  acc_type = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic        data_ok;
    logic [31:0] rdata;

    dm_uncache_ctrl_if bif ();

    dm_uncache_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .valid    (valid),
        .op       (op),
        .addr     (addr),
        .acc_type (acc_type),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .data_ok  (data_ok),
        .rdata    (rdata),
        .bus      (bif.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          op;
        logic [31:0] addr;
        logic [2:0]  t;
        logic [3:0]  strb;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        int          w;
        int          r;
        logic [7:0]  junk;
        logic [31:0] data;
    } plan_t;

    bus_exp_t exp_bus[$];
    resp_t    exp_resp[$];
    plan_t    plan_q[$];
    bit       mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: compares bus requests and completions as they appear
    initial begin : monitor
        bit       prev_ok;
        int       cyc;
        int       acc_cyc;
        bus_exp_t e;
        resp_t    rs;
        prev_ok = 1'b1;
        cyc     = 0;
        acc_cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                chk("rd_wr_exclusive", 32'(bif.rd_req & bif.wr_req), 32'd0);
                if (bif.rd_req || bif.wr_req) begin
                    if (exp_bus.size() == 0) begin
                        chk("unexpected_bus_req", 32'd1, 32'd0);
                    end else begin
                        e = exp_bus[0];
                        chk("req_kind", 32'({bif.rd_req, bif.wr_req}), e.op ? 32'd1 : 32'd2);
                        if (bif.rd_req) begin
                            chk("rd_addr", bif.rd_addr, e.addr);
                            chk("rd_type", 32'(bif.rd_type), 32'(e.t));
                        end else begin
                            chk("wr_addr", bif.wr_addr, e.addr);
                            chk("wr_type", 32'(bif.wr_type), 32'(e.t));
                            chk("wr_wstrb", 32'(bif.wr_wstrb), 32'(e.strb));
                            chk("wr_data", bif.wr_data, e.wd);
                        end
                        if ((bif.rd_req && bif.rd_rdy) || (bif.wr_req && bif.wr_rdy)) begin
                            void'(exp_bus.pop_front());
                        end
                    end
                end
                if (prev_ok && !data_ok) begin
                    acc_cyc = cyc;
                end
                if (!prev_ok && data_ok) begin
                    if (exp_resp.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        rs = exp_resp.pop_front();
                        chk("done_rdata", rdata, rs.rdata);
                        chk("done_latency", 32'(cyc - acc_cyc), 32'(rs.lat));
                    end
                end
            end
            prev_ok = data_ok;
        end
    end

    initial begin : stim
        bif.rd_rdy    = 1'b0;
        bif.wr_rdy    = 1'b0;
        bif.ret_valid = 1'b0;
        bif.ret_last  = 1'b0;
        bif.ret_data  = '0;

        // Reset state
        #2;
        chk("rst_rd_req", 32'(bif.rd_req), 32'd0);
        chk("rst_wr_req", 32'(bif.wr_req), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_data_ok", 32'(data_ok), 32'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1 chk("post_rst_data_ok", 32'(data_ok), 32'd1);

        // Single-beat word load
        @(negedge clk);
        valid = 1'b1; op = 1'b0; addr = 32'h1faf_f004; acc_type = TYPE_WORD;
        #1 chk("idle_valid_stall", 32'(data_ok), 32'd0);
        @(negedge clk);
        bif.rd_rdy = 1'b1;
        #1;
        chk("ld_rd_req", 32'(bif.rd_req), 32'd1);
        chk("ld_rd_addr", bif.rd_addr, 32'h1faf_f004);
        chk("ld_rd_type", 32'(bif.rd_type), 32'(TYPE_WORD));
        @(negedge clk);
        bif.rd_rdy = 1'b0;
        addr = 32'h1234_5678;
        #1;
        chk("rdwait_rd_req", 32'(bif.rd_req), 32'd0);
        chk("rdwait_data_ok", 32'(data_ok), 32'd0);
        @(negedge clk);
        bif.ret_valid = 1'b1; bif.ret_last = 1'b1; bif.ret_data = 32'hDEAD_BEEF;
        #1 chk("rdwait_addr_kept", bif.rd_addr, 32'h1faf_f004);
        @(negedge clk);
        bif.ret_valid = 1'b0; bif.ret_last = 1'b0;
        #1;
        chk("ld_done_data_ok", 32'(data_ok), 32'd1);
        chk("ld_rdata", rdata, 32'hDEAD_BEEF);
        valid = 1'b0;
        @(negedge clk);
        #1;
        chk("ld_idle_rd_req", 32'(bif.rd_req), 32'd0);
        chk("ld_idle_data_ok", 32'(data_ok), 32'd1);

        // Multi-beat return: only the last beat is kept
        @(negedge clk);
        valid = 1'b1; op = 1'b0; addr = 32'h1faf_f100; acc_type = TYPE_WORD;
        @(negedge clk);
        bif.rd_rdy = 1'b1;
        @(negedge clk);
        bif.rd_rdy = 1'b0;
        bif.ret_valid = 1'b1; bif.ret_last = 1'b0; bif.ret_data = 32'h1111_1111;
        @(negedge clk);
        bif.ret_last = 1'b1; bif.ret_data = 32'h2222_2222;
        #1;
        chk("mb_first_dropped", rdata, 32'hDEAD_BEEF);
        chk("mb_wait_data_ok", 32'(data_ok), 32'd0);
        @(negedge clk);
        bif.ret_valid = 1'b0; bif.ret_last = 1'b0;
        #1;
        chk("mb_done_data_ok", 32'(data_ok), 32'd1);
        chk("mb_rdata", rdata, 32'h2222_2222);
        valid = 1'b0;
        @(negedge clk);

        // Byte store with wr_rdy low for 3 cycles
        @(negedge clk);
        valid = 1'b1; op = 1'b1; addr = 32'h1faf_f001; acc_type = TYPE_BYTE;
        wstrb = 4'b0010; wdata = 32'h0000_AB00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif.wr_rdy = (i == 3);
            #1;
            chk("st_wr_req", 32'(bif.wr_req), 32'd1);
            chk("st_rd_req", 32'(bif.rd_req), 32'd0);
            chk("st_wr_addr", bif.wr_addr, 32'h1faf_f001);
            chk("st_wr_type", 32'(bif.wr_type), 32'(TYPE_BYTE));
            chk("st_wr_wstrb", 32'(bif.wr_wstrb), 32'h2);
            chk("st_wr_data", bif.wr_data, 32'h0000_AB00);
        end
        @(negedge clk);
        bif.wr_rdy = 1'b0;
        #1;
        chk("st_done_data_ok", 32'(data_ok), 32'd1);
        chk("st_done_wr_req", 32'(bif.wr_req), 32'd0);
        chk("st_rdata_kept", rdata, 32'h2222_2222);
        valid = 1'b0;
        @(negedge clk);

        // Reset while waiting for read data
        @(negedge clk);
        valid = 1'b1; op = 1'b0; addr = 32'h1faf_f008; acc_type = TYPE_WORD;
        @(negedge clk);
        bif.rd_rdy = 1'b1;
        @(negedge clk);
        bif.rd_rdy = 1'b0;
        valid = 1'b0;
        #1 chk("pre_rst_busy", 32'(data_ok), 32'd0);
        #1 resetn = 1'b0;
        #1;
        chk("async_rst_rd_req", 32'(bif.rd_req), 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        chk("async_rst_addr", bif.rd_addr, 32'd0);
        chk("async_rst_data_ok", 32'(data_ok), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bif.ret_valid = 1'b1; bif.ret_last = 1'b1; bif.ret_data = 32'hCAFE_F00D;
        @(negedge clk);
        bif.ret_valid = 1'b0; bif.ret_last = 1'b0;
        #1;
        chk("late_ret_rdata", rdata, 32'd0);
        chk("late_ret_rd_req", 32'(bif.rd_req), 32'd0);
        chk("late_ret_data_ok", 32'(data_ok), 32'd1);

        // Randomized stream, back-to-back when gap is 0
        begin : rand_phase
            logic [31:0] model_rdata;
            int          issued;
            bit          pending;
            int          gap;
            int          pend_cyc;
            int          bph;
            int          bcnt;
            int          k;
            bit          cur_rd;
            plan_t       cur;
            plan_t       pl;
            bus_exp_t    be;
            logic [31:0] ra;
            logic [2:0]  rt;
            logic [3:0]  rs;
            logic [3:0]  base;

            model_rdata = 32'd0;
            issued = 0; pending = 1'b0; gap = 0; pend_cyc = 0;
            bph = 0; bcnt = 0; k = 0; cur_rd = 1'b0;
            cur = '{0, 0, 8'd0, 32'd0};
            @(negedge clk);
            mon_en = 1'b1;
            while (issued < N_RAND || pending) begin
                @(negedge clk);
                bif.rd_rdy = 1'b0; bif.wr_rdy = 1'b0;
                bif.ret_valid = 1'b0; bif.ret_last = 1'b0;

                // Pipeline side: hold request until data_ok, then maybe next
                if (pending) begin
                    pend_cyc++;
                    if (data_ok) begin
                        pending = 1'b0;
                    end else if (pend_cyc > 100) begin
                        chk("access_timeout", 32'd1, 32'd0);
                        break;
                    end
                end
                if (!pending) begin
                    if (issued < N_RAND && gap == 0) begin
                        rt = 3'($urandom_range(0, 2));
                        ra = $urandom;
                        if (rt == TYPE_HALF) ra[0] = 1'b0;
                        if (rt == TYPE_WORD) ra[1:0] = 2'b00;
                        base = (rt == TYPE_BYTE) ? 4'b0001 : (rt == TYPE_HALF) ? 4'b0011 : 4'b1111;
                        rs = 4'(base << ra[1:0]);
                        be.op = 1'($urandom_range(0, 1));
                        be.addr = ra; be.t = rt; be.strb = rs; be.wd = $urandom;
                        pl.w = $urandom_range(0, 3);
                        pl.r = be.op ? 0 : $urandom_range(0, 3);
                        pl.junk = 8'($urandom);
                        pl.data = $urandom;
                        exp_bus.push_back(be);
                        plan_q.push_back(pl);
                        if (!be.op) model_rdata = pl.data;
                        exp_resp.push_back('{model_rdata, be.op ? 2 + pl.w : 3 + pl.w + pl.r});
                        valid = 1'b1; op = be.op; addr = ra; acc_type = rt;
                        wstrb = rs; wdata = be.wd;
                        pending = 1'b1; pend_cyc = 0; issued++;
                        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                    end else begin
                        valid = 1'b0;
                        addr = $urandom;
                        if (gap > 0) gap--;
                    end
                end

                // Bus side: wait w cycles before rdy, then r filler cycles
                if (bph == 0 && (bif.rd_req || bif.wr_req)) begin
                    if (plan_q.size() == 0) begin
                        chk("bus_plan_missing", 32'd1, 32'd0);
                    end else begin
                        cur = plan_q.pop_front();
                        cur_rd = bif.rd_req;
                        bcnt = cur.w;
                        bph = 1;
                    end
                end
                if (bph == 1) begin
                    if (bcnt == 0) begin
                        if (cur_rd) begin
                            bif.rd_rdy = 1'b1;
                            bph = 2;
                            k = 0;
                        end else begin
                            bif.wr_rdy = 1'b1;
                            bph = 0;
                        end
                    end else begin
                        bcnt--;
                    end
                end else if (bph == 2) begin
                    if (k < cur.r) begin
                        bif.ret_valid = cur.junk[k];
                        bif.ret_last = 1'b0;
                        bif.ret_data = $urandom;
                        k++;
                    end else begin
                        bif.ret_valid = 1'b1;
                        bif.ret_last = 1'b1;
                        bif.ret_data = cur.data;
                        bph = 0;
                    end
                end
            end
            valid = 1'b0;
            repeat (4) @(negedge clk);
            #2;
            chk("exp_bus_drained", 32'(exp_bus.size()), 32'd0);
            chk("exp_resp_drained", 32'(exp_resp.size()), 32'd0);
            chk("final_rdata", rdata, model_rdata);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
